uart_tx_serializer: RTL and testbench

UART_TX_SERIALIZER -- requirements
Module: uart_tx_serializer

---
 rtl/uart_tx_serializer.sv | 132 +++++++++++++
 tb/tb_uart_tx_serializer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_serializer.sv
// UART transmitter: byte FIFO feeding an 8N1 serializer paced by oversampling ticks (tick = fr_div==0).
// Start bit appears on the first tick after a byte is queued; rdy_tx drops only while the FIFO is full.
module uart_tx_serializer #(
  parameter int OVS        = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] fr_div,
  input  logic [7:0] d_tx,
  input  logic       vld_tx,
  output logic       rdy_tx,
  output logic       txd,
  output logic       busy,
  output logic       tx_done,
  output logic [2:0] fifo_cnt
);

  localparam int              AW      = $clog2(FIFO_DEPTH);
  localparam logic [2:0]      DEPTH_C = 3'(FIFO_DEPTH);
  localparam logic [3:0]      TLAST   = 4'(OVS - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t         state;
  logic [3:0]     tcnt;
  logic [2:0]     bidx;
  logic [7:0]     shreg;
  logic [7:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]  wptr;
  logic [AW-1:0]  rptr;
  logic           tick;
  logic           bit_end;
  logic           push;
  logic           pop;

  assign tick    = (fr_div == 4'd0);
  assign bit_end = tick && (tcnt == TLAST);
  assign rdy_tx  = (fifo_cnt < DEPTH_C);
  assign push    = vld_tx && rdy_tx;
  // Pops happen only when the line is free: from IDLE, or back-to-back at the end of a stop bit
  assign pop     = (fifo_cnt != 3'd0) && tick &&
                   ((state == IDLE) || ((state == STOP) && (tcnt == TLAST)));
  assign busy    = (state != IDLE) || (fifo_cnt != 3'd0);

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= d_tx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr     <= '0;
      rptr     <= '0;
      fifo_cnt <= 3'd0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      fifo_cnt <= fifo_cnt + {2'b00, push} - {2'b00, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      txd     <= 1'b1;
      tx_done <= 1'b0;
      tcnt    <= 4'd0;
      bidx    <= 3'd0;
      shreg   <= 8'd0;
    end else begin
      tx_done <= 1'b0;
      if (tick) begin
        case (state)
          IDLE: begin
            if (pop) begin
              shreg <= mem[rptr];
              tcnt  <= 4'd0;
              state <= START;
              txd   <= 1'b0;
            end
          end
          START: begin
            if (bit_end) begin
              tcnt  <= 4'd0;
              bidx  <= 3'd0;
              state <= DATA;
              txd   <= shreg[0];
              shreg <= shreg >> 1;
            end else begin
              tcnt <= tcnt + 4'd1;
            end
          end
          DATA: begin
            if (bit_end) begin
              tcnt <= 4'd0;
              if (bidx == 3'd7) begin
                state <= STOP;
                txd   <= 1'b1;
              end else begin
                bidx  <= bidx + 3'd1;
                txd   <= shreg[0];
                shreg <= shreg >> 1;
              end
            end else begin
              tcnt <= tcnt + 4'd1;
            end
          end
          STOP: begin
            if (bit_end) begin
              tcnt    <= 4'd0;
              tx_done <= 1'b1;
              if (pop) begin
                shreg <= mem[rptr];
                state <= START;
                txd   <= 1'b0;
              end else begin
                state <= IDLE;
              end
            end else begin
              tcnt <= tcnt + 4'd1;
            end
          end
          default: begin
            state <= IDLE;
            txd   <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: vector table, directed frame sequences, and random traffic
// checked every cycle against a frame-level reference model.
module tb_uart_tx_serializer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       vld = 1'b0;
  logic [3:0] frd = 4'd1;
  logic [7:0] d   = 8'd0;
  logic       rdy, txd, busy, done;
  logic [2:0] cnt;

  always #5 clk = ~clk;

  uart_tx_serializer #(.OVS(16), .FIFO_DEPTH(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .fr_div   (frd),
    .d_tx     (d),
    .vld_tx   (vld),
    .rdy_tx   (rdy),
    .txd      (txd),
    .busy     (busy),
    .tx_done  (done),
    .fifo_cnt (cnt)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int done_cnt = 0;
  int done_times[$];
  bit frun = 1'b0;

  // Reference model: queue of pending bytes, and remaining ticks of the frame on the line
  logic [7:0] q[$];
  int         rem = 0;
  logic [7:0] cur = 8'd0;
  logic       m_done = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic m_txd();
    int e;
    int k;
    if (rem == 0) return 1'b1;
    e = 160 - rem;
    k = e / 16;
    if (k == 0) return 1'b0;
    if (k >= 9) return 1'b1;
    return cur[k-1];
  endfunction

  task automatic model_update();
    int   pre_n;
    logic acc;
    m_done = 1'b0;
    if (rst) begin
      q.delete();
      rem = 0;
      return;
    end
    pre_n = q.size();
    acc   = vld && (pre_n < 4);
    if (frd == 4'd0) begin
      if (rem > 0) begin
        rem--;
        if (rem == 0) m_done = 1'b1;
      end
      if (rem == 0 && pre_n > 0) begin
        cur = q.pop_front();
        rem = 160;
      end
    end
    if (acc) q.push_back(d);
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    cyc++;
    #1;
    if (done === 1'b1) begin
      done_cnt++;
      done_times.push_back(cyc);
    end
    chk("model_txd",  txd,  m_txd());
    chk("model_rdy",  rdy,  q.size() < 4);
    chk("model_cnt",  cnt,  q.size());
    chk("model_busy", busy, (rem != 0) || (q.size() != 0));
    chk("model_done", done, m_done);
    if (frun) frd = frd + 4'd1;
  endtask

  typedef struct {
    logic       rst;
    logic       vld;
    logic [7:0] d;
    logic [3:0] fr;
    logic       e_rdy;
    logic [2:0] e_cnt;
    logic       e_busy;
    logic       e_txd;
  } vec_t;

  vec_t tbl[12];

  initial begin
    logic [9:0] a5_bits;
    logic [7:0] b4[4];
    int lat;
    int n;

    //          rst   vld   d      fr     rdy   cnt   busy  txd
    tbl[0]  = '{1'b1, 1'b0, 8'h00, 4'd5, 1'b1, 3'd0, 1'b0, 1'b1};
    tbl[1]  = '{1'b0, 1'b1, 8'h11, 4'd5, 1'b1, 3'd1, 1'b1, 1'b1};
    tbl[2]  = '{1'b0, 1'b1, 8'h22, 4'd5, 1'b1, 3'd2, 1'b1, 1'b1};
    tbl[3]  = '{1'b0, 1'b1, 8'h33, 4'd5, 1'b1, 3'd3, 1'b1, 1'b1};
    tbl[4]  = '{1'b0, 1'b1, 8'h44, 4'd5, 1'b0, 3'd4, 1'b1, 1'b1};
    tbl[5]  = '{1'b0, 1'b1, 8'h99, 4'd5, 1'b0, 3'd4, 1'b1, 1'b1};
    tbl[6]  = '{1'b0, 1'b0, 8'h00, 4'd5, 1'b0, 3'd4, 1'b1, 1'b1};
    tbl[7]  = '{1'b1, 1'b0, 8'h00, 4'd5, 1'b1, 3'd0, 1'b0, 1'b1};
    tbl[8]  = '{1'b0, 1'b1, 8'h5A, 4'd3, 1'b1, 3'd1, 1'b1, 1'b1};
    tbl[9]  = '{1'b0, 1'b0, 8'h00, 4'd0, 1'b1, 3'd0, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 8'h66, 4'd1, 1'b1, 3'd1, 1'b1, 1'b0};
    tbl[11] = '{1'b1, 1'b1, 8'h77, 4'd0, 1'b1, 3'd0, 1'b0, 1'b1};

    for (int i = 0; i < 12; i++) begin
      rst = tbl[i].rst;
      vld = tbl[i].vld;
      d   = tbl[i].d;
      frd = tbl[i].fr;
      step();
      chk($sformatf("vec%0d_rdy", i),  rdy,  tbl[i].e_rdy);
      chk($sformatf("vec%0d_cnt", i),  cnt,  tbl[i].e_cnt);
      chk($sformatf("vec%0d_busy", i), busy, tbl[i].e_busy);
      chk($sformatf("vec%0d_txd", i),  txd,  tbl[i].e_txd);
    end
    rst = 1'b0;
    vld = 1'b0;

    // Single 0xA5 frame with a free-running divider: 256 clocks per bit
    rst = 1'b1; step(); rst = 1'b0;
    frd = 4'd1; frun = 1'b1; done_cnt = 0;
    vld = 1'b1; d = 8'hA5; step(); vld = 1'b0;
    lat = 0;
    while (txd !== 1'b0 && lat < 40) begin
      step();
      lat++;
    end
    chk("a5_start_seen", txd, 1'b0);
    chk("a5_latency_ok", lat <= 18, 1'b1);
    a5_bits = {1'b1, 8'hA5, 1'b0};
    for (int k = 0; k < 10; k++) begin
      repeat ((k == 0) ? 128 : 256) step();
      chk($sformatf("a5_bit%0d", k), txd, a5_bits[k]);
    end
    repeat (200) step();
    chk("a5_done_count", done_cnt, 1);
    chk("a5_busy_after", busy, 1'b0);
    chk("a5_txd_idle", txd, 1'b1);

    // Four back-to-back bytes: FIFO fills before the first pop, frames abut
    rst = 1'b1; step(); rst = 1'b0;
    frd = 4'd1; done_cnt = 0; done_times.delete();
    b4[0] = 8'h00; b4[1] = 8'hFF; b4[2] = 8'h55; b4[3] = 8'hAA;
    for (int i = 0; i < 4; i++) begin
      vld = 1'b1; d = b4[i]; step();
    end
    vld = 1'b0;
    chk("b2b_rdy_full", rdy, 1'b0);
    chk("b2b_cnt_full", cnt, 3'd4);
    for (int i = 0; i < 12000 && (done_cnt < 4 || busy); i++) step();
    chk("b2b_done_count", done_cnt, 4);
    if (done_times.size() == 4) begin
      for (int i = 1; i < 4; i++)
        chk($sformatf("b2b_gap%0d", i), done_times[i] - done_times[i-1], 2560);
    end
    chk("b2b_busy_after", busy, 1'b0);

    // Reset 1000 clocks into a frame, with a second byte buffered
    rst = 1'b1; step(); rst = 1'b0;
    frd = 4'd1;
    vld = 1'b1; d = 8'h3C; step(); vld = 1'b0;
    for (int i = 0; i < 40 && txd !== 1'b0; i++) step();
    vld = 1'b1; d = 8'h77; step(); vld = 1'b0;
    repeat (1000) step();
    n = done_cnt;
    rst = 1'b1; step(); rst = 1'b0;
    chk("rst_txd",  txd,  1'b1);
    chk("rst_cnt",  cnt,  3'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_rdy",  rdy,  1'b1);
    repeat (50) step();
    chk("rst_no_done", done_cnt, n);
    frun = 1'b0; frd = 4'd0;
    vld = 1'b1; d = 8'hC3; step(); vld = 1'b0;
    repeat (170) step();
    chk("rst_clean_done", done_cnt, n + 1);
    chk("rst_clean_idle", busy, 1'b0);

    // Random traffic, random tick pattern, rare resets
    for (int i = 0; i < 4000; i++) begin
      frd = 4'($urandom_range(0, 3));
      vld = 1'($urandom_range(0, 1));
      d   = 8'($urandom_range(0, 255));
      rst = ($urandom_range(0, 599) == 0);
      step();
    end
    rst = 1'b0;
    vld = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
